// File: rtl/button_reader_if.sv
// Button bus: raw active-low buttons in, debounced levels and event pulses out.
interface button_reader_if #(
    parameter int unsigned NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_n;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_long;
    logic               btn_any;

    modport master (
        output btn_n,
        input  btn_level, btn_press, btn_release, btn_long, btn_any
    );

    modport slave (
        input  btn_n,
        output btn_level, btn_press, btn_release, btn_long, btn_any
    );
endinterface

// File: rtl/button_reader.sv
// Multi-channel button reader: synchronize, debounce, and emit press/release/long-press pulses.
module button_reader #(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned LONG_CYCLES     = 12000000
) (
    input  logic           hwclk,
    input  logic           rst,
    button_reader_if.slave bus
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    logic [NUM_BTN-1:0] level_v;
    logic [NUM_BTN-1:0] level_nx_v;
    logic [NUM_BTN-1:0] press_v;
    logic [NUM_BTN-1:0] release_v;
    logic [NUM_BTN-1:0] long_v;
    logic               any_q;
    logic               any_d;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        logic              sync1_q;
        logic              sample_q;
        logic              level_q,   level_d;
        logic [DB_W-1:0]   db_cnt_q,  db_cnt_d;
        logic [HOLD_W-1:0] hold_q,    hold_d;
        state_e            state_q,   state_d;
        logic              press_q,   press_d;
        logic              release_q, release_d;
        logic              long_q,    long_d;
        logic              rise_c;
        logic              fall_c;

        always_ff @(posedge hwclk) begin
            if (rst) begin
                sync1_q   <= 1'b0;
                sample_q  <= 1'b0;
                level_q   <= 1'b0;
                db_cnt_q  <= '0;
                hold_q    <= '0;
                state_q   <= ST_RELEASED;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                sync1_q   <= ~bus.btn_n[g];
                sample_q  <= sync1_q;
                level_q   <= level_d;
                db_cnt_q  <= db_cnt_d;
                hold_q    <= hold_d;
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        // Debounce, then drive the press FSM from the level transition on this same edge
        always_comb begin
            db_cnt_d  = '0;
            level_d   = level_q;
            hold_d    = hold_q;
            state_d   = state_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;

            if (sample_q != level_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            rise_c = ~level_q &  level_d;
            fall_c =  level_q & ~level_d;

            unique case (state_q)
                ST_RELEASED: begin
                    if (rise_c) begin
                        state_d = ST_PRESSED;
                        hold_d  = '0;
                        press_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // A release landing on the long-press edge suppresses btn_long
                    if (fall_c) begin
                        state_d   = ST_RELEASED;
                        hold_d    = '0;
                        release_d = 1'b1;
                    end else if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
                        state_d = ST_HELD;
                        hold_d  = hold_q + 1'b1;
                        long_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (fall_c) begin
                        state_d   = ST_RELEASED;
                        hold_d    = '0;
                        release_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    hold_d  = '0;
                end
            endcase
        end

        assign level_v[g]    = level_q;
        assign level_nx_v[g] = level_d;
        assign press_v[g]    = press_q;
        assign release_v[g]  = release_q;
        assign long_v[g]     = long_q;
    end

    // Registered from next-state levels so it tracks btn_level cycle for cycle
    assign any_d = |level_nx_v;

    always_ff @(posedge hwclk) begin
        if (rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_long    = long_v;
    assign bus.btn_any     = any_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_button_reader;

    logic hwclk = 1'b0;
    logic rst   = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    button_reader_if #(.NUM_BTN(4)) bus ();

    button_reader #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10)
    ) dut (
        .hwclk(hwclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 hwclk = ~hwclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_any});
    endfunction

    initial begin
        bus.btn_n = 4'hF;
        tick();
        tick();
        check("reset_outs", outs(), 32'h0);

        // Idle, nothing pressed
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("idle_%0d", k), outs(), 32'h0);
        end

        // Three-cycle glitch on button 1 must be swallowed
        bus.btn_n = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("glitch_low_%0d", k), outs(), 32'h0);
        end
        bus.btn_n = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("glitch_after_%0d", k), outs(), 32'h0);
        end

        // Press button 0: level and press on edge 6
        bus.btn_n = 4'b1110;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 6) begin
                check($sformatf("p0_wait_%0d", k), outs(), 32'h0);
            end else begin
                check("p0_level", 32'(bus.btn_level), 32'h1);
                check("p0_press", 32'(bus.btn_press), 32'h1);
                check("p0_any", 32'(bus.btn_any), 32'h1);
            end
        end
        tick();
        check("p0_press_once", 32'(bus.btn_press), 32'h0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            check($sformatf("p0_nolong_%0d", k), 32'(bus.btn_long), 32'h0);
        end
        tick();
        check("p0_long", 32'(bus.btn_long), 32'h1);
        check("p0_long_level", 32'(bus.btn_level), 32'h1);
        for (int k = 0; k < 50; k++) begin
            tick();
            check($sformatf("p0_held_%0d", k),
                  32'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long}), 32'h1000);
        end

        // Release button 0 from HELD
        bus.btn_n = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 6) begin
                check($sformatf("r0_wait_%0d", k),
                      32'({bus.btn_level, bus.btn_release, bus.btn_long}), 32'h100);
            end else begin
                check("r0_release", 32'(bus.btn_release), 32'h1);
                check("r0_level", 32'(bus.btn_level), 32'h0);
                check("r0_nolong", 32'(bus.btn_long), 32'h0);
                check("r0_any", 32'(bus.btn_any), 32'h0);
            end
        end
        tick();
        check("r0_release_once", outs(), 32'h0);

        // Buttons 2 and 3 together
        bus.btn_n = 4'b0011;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 6) begin
                check($sformatf("p23_wait_%0d", k), outs(), 32'h0);
            end else begin
                check("p23_press", 32'(bus.btn_press), 32'hC);
                check("p23_level", 32'(bus.btn_level), 32'hC);
                check("p23_any", 32'(bus.btn_any), 32'h1);
            end
        end
        tick();
        check("p23_press_once", 32'(bus.btn_press), 32'h0);
        bus.btn_n = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("p23_nolong_%0d", k), 32'(bus.btn_long), 32'h0);
            if (k == 6) begin
                check("p23_release", 32'(bus.btn_release), 32'hC);
                check("p23_rel_level", 32'(bus.btn_level), 32'h0);
            end
        end

        // Reset while button 0 is HELD, button kept down through reset
        bus.btn_n = 4'b1110;
        repeat (6) tick();
        check("rh_press", 32'(bus.btn_press), 32'h1);
        repeat (10) tick();
        check("rh_long", 32'(bus.btn_long), 32'h1);
        repeat (2) tick();
        check("rh_held_level", 32'(bus.btn_level), 32'h1);
        rst = 1'b1;
        tick();
        check("rh_reset_outs", outs(), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 6) begin
                check($sformatf("rh_wait_%0d", k), outs(), 32'h0);
            end else begin
                check("rh_repress", 32'(bus.btn_press), 32'h1);
                check("rh_relevel", 32'(bus.btn_level), 32'h1);
                check("rh_norelease", 32'(bus.btn_release), 32'h0);
            end
        end

        // Release landing on the same edge the hold count reaches LONG_CYCLES
        repeat (4) tick();
        bus.btn_n = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("rw_nolong_%0d", k), 32'(bus.btn_long), 32'h0);
            if (k == 6) begin
                check("rw_release", 32'(bus.btn_release), 32'h1);
                check("rw_level", 32'(bus.btn_level), 32'h0);
            end
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rw_quiet_%0d", k), outs(), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 SHALL provide parameter NUM_BTN, default 4: number of independent button channels.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 120000: consecutive stable synchronized samples needed to accept a level change (10 ms at 12 MHz); legal range >= 2.
REQ-003 SHALL provide parameter LONG_CYCLES, default 12000000: cycles a debounced press is held before a long-press event (1 s at 12 MHz); legal range >= 1.
REQ-004 SHALL have port: hwclk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: btn_n  input  NUM_BTN  raw asynchronous buttons, active-low (0 = pressed).
REQ-007 SHALL have port: btn_level  output  NUM_BTN  debounced state, 1 = pressed.
REQ-008 SHALL have port: btn_press  output  NUM_BTN  one-cycle pulse on debounced press.
REQ-009 SHALL have port: btn_release  output  NUM_BTN  one-cycle pulse on debounced release.
REQ-010 SHALL have port: btn_long  output  NUM_BTN  one-cycle pulse when a press reaches LONG_CYCLES.
REQ-011 SHALL have port: btn_any  output  1  OR-reduction of btn_level.

Function
REQ-012 Each btn_n bit SHALL pass through a 2-flop synchronizer, inverted to active-high; the second-flop output is the "sample".
REQ-013 Each channel SHALL be fully independent; no cross-channel interaction except btn_any.
REQ-014 Per channel: debounce counter, width $clog2(DEBOUNCE_CYCLES)+1; increments each cycle sample != btn_level; clears to 0 any cycle sample == btn_level.
REQ-015 When sample != btn_level and counter == DEBOUNCE_CYCLES-1, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-016 Latency: after raw input changes and stays stable, btn_level SHALL change exactly 2+DEBOUNCE_CYCLES edges after the first edge sampling the new raw value.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no level change and no pulse.
REQ-018 Per-channel state machine: RELEASED, PRESSED, HELD; reset state RELEASED.
REQ-019 RELEASED -> PRESSED on the edge btn_level rises; btn_press high for exactly that following cycle (same cycle btn_level first reads 1).
REQ-020 PRESSED: hold counter (width $clog2(LONG_CYCLES)+1) increments each cycle from 0; on reaching LONG_CYCLES -> HELD with btn_long high for exactly one cycle.
REQ-021 HELD: hold counter frozen; no further btn_long until a release and new press.
REQ-022 PRESSED or HELD -> RELEASED on the edge btn_level falls; btn_release high for exactly that cycle; hold counter clears.
REQ-023 Release on the same edge the hold counter would reach LONG_CYCLES: release wins, btn_long SHALL NOT pulse.
REQ-024 btn_press, btn_release, btn_long SHALL be registered outputs; never more than one of them high per channel per cycle.
REQ-025 btn_any SHALL equal |btn_level in the same cycle.

Reset
REQ-026 While rst high: btn_level, btn_press, btn_release, btn_long, btn_any = 0; all counters 0; all channels RELEASED; synchronizer flops = released.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort without emitting any pulse, including no btn_release.
REQ-028 A button held through reset SHALL be reported as a new press 2+DEBOUNCE_CYCLES edges after rst deasserts.

Verification (NUM_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-029 Reset, btn_n=4'hF for 20 cycles -> all outputs 0 throughout.
REQ-030 btn_n[0] driven low and held -> btn_level[0]=1 and btn_press[0] one-cycle pulse at edge 6 after first sampling edge; btn_any=1.
REQ-031 btn_n[1] low for 3 cycles then high -> btn_level[1], btn_press[1], btn_release[1] stay 0.
REQ-032 Hold btn 0 -> btn_long[0] single pulse 10 cycles after btn_level[0] rise; hold 50 more cycles, no repeat; release -> btn_release[0] pulse 6 edges later, no btn_long.
REQ-033 btn_n[2] and btn_n[3] low same cycle -> btn_press[2] and btn_press[3] pulse in same cycle; btn_level reads 4'b1100.
REQ-034 rst high one cycle while btn 0 in HELD -> outputs 0 next cycle, no btn_release; btn_press[0] re-pulses 6 edges after rst deasserts.
